// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V front end: instruction width, PC step and reset vector.
package riscv_pkg;

  localparam int          INSTR_WIDTH = 32;
  localparam int          PC_STEP     = 4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO holding {pc, instr} pairs; the head is visible combinationally
// and reads as zero when the FIFO is empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(do_push && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, prefetch buffering and redirect flush
// with discard of stale in-flight responses.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(riscv_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0]   fetch_pc;
  logic [DATA_WIDTH-1:0]   return_pc;
  logic [DATA_WIDTH-1:0]   target_pc;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           discard;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             in_use;
  logic                    req_fire;
  logic                    rsp_fire;
  logic                    push;
  logic                    pop;
  logic [2*DATA_WIDTH-1:0] head;

  assign target_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};

  // Credits cover both in-flight and buffered words, so a push never finds the FIFO full.
  assign imem_req_valid = !rst && !redirect_valid && (in_use < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to fetches dropped by a reset.
  assign rsp_fire = imem_rsp_valid && (outstanding != '0) && !rst;
  assign push     = rsp_fire && (discard == '0) && !redirect_valid;
  assign pop      = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (fifo_count != '0) && !rst;
  assign instr       = rst ? '0 : head[DATA_WIDTH-1:0];
  assign instr_pc    = rst ? '0 : head[2*DATA_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      return_pc   <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
        fetch_pc  <= target_pc;
        return_pc <= target_pc;
        discard   <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + DATA_WIDTH'(PC_STEP);
        if (push) return_pc <= return_pc + DATA_WIDTH'(PC_STEP);
        if (rsp_fire && discard != '0) discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH(2 * DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wr_data({return_pc, imem_rsp_data}),
    .rd_data(head),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          n_req = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];

  fetch_unit #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(2),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // One clock: log the handshake, cross the edge, then let memory present any due response.
  task automatic tick();
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + mem_lat);
      req_log.push_back(imem_req_addr);
      n_req++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    tick();
    tick();
    rst = 1'b0;
    req_log.delete();
    n_req = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
    rst = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL release_req_valid: got %b expected 1", imem_req_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int got;
    mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    exp_pc = 32'h0;
    got = 0;
    for (int n = 0; n < 40 && got < 6; n++) begin
      if (instr_valid) begin
        total++; if (instr_pc !== exp_pc) begin bad++; $display("[TB] FAIL stream_pc: got %h expected %h", instr_pc, exp_pc); end
        total++; if (instr !== word_of(exp_pc)) begin bad++; $display("[TB] FAIL stream_instr: got %h expected %h", instr, word_of(exp_pc)); end
        exp_pc += 32'd4;
        got++;
      end
      tick();
    end
    total++; if (got != 6) begin bad++; $display("[TB] FAIL stream_timeout: got %0d expected 6", got); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= req_log.size() || req_log[i] !== 32'(i * 4)) begin
        bad++; $display("[TB] FAIL stream_req_addr[%0d]: got %h expected %h", i, (i < req_log.size()) ? req_log[i] : 32'hx, 32'(i * 4));
      end
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
    apply_reset();
    for (int n = 0; n < 10; n++) tick();
    total++; if (n_req != 2) begin bad++; $display("[TB] FAIL bp_req_count: got %0d expected 2", n_req); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("[TB] FAIL bp_head0: got valid=%b pc=%h expected valid=1 pc=0", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    tick();
    total++; if (instr_pc !== 32'h4) begin bad++; $display("[TB] FAIL bp_head1_pc: got %h expected 4", instr_pc); end
    total++; if (instr !== word_of(32'h4)) begin bad++; $display("[TB] FAIL bp_head1_instr: got %h expected %h", instr, word_of(32'h4)); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("[TB] FAIL bp_resume: got valid=%b addr=%h expected valid=1 addr=8", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stall();
    mem_lat = 1; imem_req_ready = 1'b0; instr_ready = 1'b1;
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      tick();
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("[TB] FAIL stall_hold: got valid=%b addr=%h expected valid=1 addr=0", imem_req_valid, imem_req_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_fifo: got %b expected 0", instr_valid); end
    end
    imem_req_ready = 1'b1;
    tick();
    total++; if (imem_req_addr !== 32'h4 || n_req != 1) begin bad++; $display("[TB] FAIL stall_release: got addr=%h reqs=%0d expected addr=4 reqs=1", imem_req_addr, n_req); end
  endtask

  task automatic test_redirect();
    int n;
    mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_no_req: got %b expected 0", imem_req_valid); end
    req_log.delete();
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
    total++; if (instr_pc !== 32'h100 || instr !== word_of(32'h100)) begin bad++; $display("[TB] FAIL redir_first_instr: got pc=%h instr=%h expected pc=100 instr=%h", instr_pc, instr, word_of(32'h100)); end
    total++; if (req_log.size() == 0 || req_log[0] !== 32'h100) begin bad++; $display("[TB] FAIL redir_first_req: got %h expected 100", (req_log.size() != 0) ? req_log[0] : 32'hx); end
  endtask

  task automatic test_redirect_rsp();
    int n;
    mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    tick();
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rr_setup: got valid=%b pc=%h rsp=%b expected 1 0 1", instr_valid, instr_pc, imem_rsp_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL rr_flushed: got %b expected 0", instr_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin bad++; $display("[TB] FAIL rr_next_req: got valid=%b addr=%h expected valid=1 addr=200", imem_req_valid, imem_req_addr); end
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    total++; if (instr_pc !== 32'h200 || instr !== word_of(32'h200)) begin bad++; $display("[TB] FAIL rr_first_instr: got pc=%h instr=%h expected pc=200", instr_pc, instr); end
  endtask

  task automatic test_reset_mid();
    int n;
    mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    tick();
    rst = 1'b1;
    tick();
    total++; if ({imem_req_valid, instr_valid, instr, instr_pc, imem_req_addr} !== '0) begin bad++; $display("[TB] FAIL midrst_outputs: got rv=%b iv=%b instr=%h pc=%h addr=%h expected all 0", imem_req_valid, instr_valid, instr, instr_pc, imem_req_addr); end
    rst = 1'b0;
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_stale: got %b expected 0 (pc=%h)", instr_valid, instr_pc); end
    end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("[TB] FAIL midrst_addr: got %h expected 0", imem_req_addr); end
    imem_req_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== word_of(32'h0)) begin bad++; $display("[TB] FAIL midrst_restart: got valid=%b pc=%h instr=%h expected 1 0 %h", instr_valid, instr_pc, instr, word_of(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle datapath.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Buffers returned instruction words with their PCs in a small prefetch FIFO and presents them to the datapath under a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes buffered and in-flight fetches.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- FIFO_DEPTH, 2, prefetch buffer entries; also the cap on outstanding plus buffered fetches (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  DATA_WIDTH  new fetch address; bits [1:0] ignored (forced to 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  DATA_WIDTH  fetch address.
- imem_rsp_valid  in  1  response word valid; in-order, latency ≥1 cycle, no backpressure.
- imem_rsp_data  in  DATA_WIDTH  instruction word.
- instr_valid  out  1  buffered instruction available.
- instr_ready  in  1  datapath consumes instruction.
- instr  out  DATA_WIDTH  instruction word (FIFO head).
- instr_pc  out  DATA_WIDTH  PC of instr.

Behaviour:
- Reset (rst=1 at an edge): fetch_pc=RESET_PC; outstanding=0; discard=0; FIFO empty with pointers 0. While rst is high, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0. Reset mid-operation drops all buffered and in-flight state; responses arriving after reset are ignored until outstanding is nonzero again.
- Issue: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). imem_req_addr = fetch_pc. On req handshake: fetch_pc += 4 (wraps modulo 2^DATA_WIDTH), outstanding++.
- Response: on imem_rsp_valid, outstanding-- (net of any same-cycle issue).
  - If discard>0 or redirect_valid: discard-- if nonzero; word dropped.
  - Otherwise push {pc, word}; pc comes from an internal return-PC counter that advances by 4 per accepted response.
  - The credit rule guarantees the FIFO is never full on a push. A push to a full FIFO is an assertion failure.
- Output: show-ahead FIFO. instr_valid = (fifo_count != 0) && !rst; instr/instr_pc show the head entry, and read 0 when empty. Pop on instr_valid && instr_ready && !redirect_valid. Simultaneous push and pop leaves the count unchanged. Minimum latency from response to instr_valid is 1 cycle (registered FIFO).
- Redirect (redirect_valid=1 at an edge): FIFO flushed; fetch_pc and return-PC <= {redirect_pc[DW-1:2],2'b00}; discard <= outstanding minus any response consumed this cycle; no request issued this cycle. The first post-redirect request goes out on the next cycle.
- Back-to-back redirects: the last one wins; discard tracks all stale in-flight responses.
- FSM: none explicit. Control state is the counters {outstanding, discard, fifo_count} plus the two PC registers. The invariant outstanding + fifo_count ≤ FIFO_DEPTH holds every cycle.

Decomposition:
- Shared package riscv_pkg: INSTR_WIDTH=32, PC_STEP=4, RESET_PC default, NOP_INSTR=32'h0000_0013 (for benches).
- One sub-module: fetch_fifo. Synchronous show-ahead FIFO, parameters WIDTH/DEPTH, ports push/pop/flush/count, storing {pc, instr}.

Test Plan:
- Reset release, memory with 1-cycle latency, instr_ready=1 → requests at 0x0, 0x4, 0x8…; instr_pc sequence 0x0, 0x4, 0x8 matching words; sustained 1 instr/cycle after fill.
- instr_ready=0 for 10 cycles → exactly FIFO_DEPTH=2 requests issued, imem_req_valid=0 afterwards. On ready=1, entries for 0x0 and 0x4 are consumed in order, then fetching resumes at 0x8.
- imem_req_ready=0 for 5 cycles → imem_req_addr held at 0x0, no FIFO activity, no PC advance.
- Redirect to 0x103 with 2 fetches in flight (3-cycle memory latency) → both stale responses dropped. Next request is 0x100; first instr_pc is 0x100.
- Redirect in the same cycle as imem_rsp_valid and instr_ready → response dropped, no pop, FIFO empty next cycle, discard = remaining outstanding.
- rst asserted mid-stream with 1 fetch in flight → the cycle after, all outputs are 0. Fetch restarts at RESET_PC, and the late stale response is not presented.
